// File: rtl/bpsk_frame_pkg.sv
// Shared types and defaults for the BPSK receive deframer.
package bpsk_frame_pkg;

  localparam int SYNC_WIDTH = 16;
  localparam int BYTE_WIDTH = 8;

  localparam logic [SYNC_WIDTH-1:0] DEFAULT_SYNC_WORD       = 16'hD391;
  localparam int                    DEFAULT_SAMPLES_PER_BIT = 20;

  // Frame-level receive state: hunting for sync, then length, payload, checksum.
  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LEN  = 2'd1,
    PAY  = 2'd2,
    CHK  = 2'd3
  } state_t;

endpackage

// File: rtl/bpsk_bit_sync.sv
// Bit timing recovery: edge detect on the demodulated stream, a phase counter
// that re-aligns on every edge, and a mid-bit sample strobe.
module bpsk_bit_sync
  import bpsk_frame_pkg::*;
#(
  parameter int SAMPLES_PER_BIT = DEFAULT_SAMPLES_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic bit_i,
  output logic strobe_o,
  output logic bit_o
);

  localparam int             PW     = $clog2(SAMPLES_PER_BIT);
  localparam logic [PW-1:0]  PH_MAX = PW'(SAMPLES_PER_BIT - 1);
  localparam logic [PW-1:0]  PH_MID = PW'(SAMPLES_PER_BIT / 2);
  localparam logic [PW-1:0]  PH_ONE = PW'(1);

  logic          bit_q;
  logic [PW-1:0] phase_q, phase_d;
  logic          edge_det;

  assign edge_det = (bit_i != bit_q);

  // An edge marks the start of a bit; otherwise free-run modulo one bit period.
  always_comb begin
    if (edge_det)              phase_d = PH_ONE;
    else if (phase_q == PH_MAX) phase_d = '0;
    else                        phase_d = phase_q + PH_ONE;
  end

  // Input register and phase counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_q   <= 1'b0;
      phase_q <= '0;
    end else begin
      bit_q   <= bit_i;
      phase_q <= phase_d;
    end
  end

  // Strobe lands half a bit after the last edge; suppressed while disabled.
  assign strobe_o = en_i && (phase_q == PH_MID);
  assign bit_o    = bit_q;

endmodule

// File: rtl/bpsk_deframer.sv
// BPSK receive deframer: bit sync, sync-word hunt, length / payload /
// checksum extraction. Optional build macro POLARITY_AUTO_EN adds detection
// of an inverted sync word and per-frame bit inversion (180 deg ambiguity).
module bpsk_deframer
  import bpsk_frame_pkg::*;
#(
  parameter int                    SAMPLES_PER_BIT = DEFAULT_SAMPLES_PER_BIT,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD       = DEFAULT_SYNC_WORD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  bit_in,
  output logic [BYTE_WIDTH-1:0] byte_out,
  output logic                  byte_valid,
  output logic                  sof,
  output logic                  eof,
  output logic                  chk_err,
  output logic                  locked,
  output logic                  polarity_inv
);

  logic strobe;
  logic bit_s;

  bpsk_bit_sync #(
    .SAMPLES_PER_BIT(SAMPLES_PER_BIT)
  ) u_bit_sync (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en),
    .bit_i   (bit_in),
    .strobe_o(strobe),
    .bit_o   (bit_s)
  );

  state_t                  state_q, state_d;
  logic [SYNC_WIDTH-1:0]   sh_q, sh_d;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic [BYTE_WIDTH-1:0]   len_q, len_d;
  logic [BYTE_WIDTH-1:0]   cnt_q, cnt_d;
  logic [BYTE_WIDTH-1:0]   sum_q, sum_d;
  logic [BYTE_WIDTH-1:0]   byte_q, byte_d;
  logic                    valid_q, valid_d;
  logic                    sof_q, sof_d;
  logic                    eof_q, eof_d;
  logic                    chk_err_q, chk_err_d;
  logic                    pol_q, pol_d;

  logic                    in_bit;
  logic [SYNC_WIDTH-1:0]   rx_word;
  logic [BYTE_WIDTH-1:0]   rx_byte;

  // Hunt sees the raw bit; inside a frame the polarity correction applies.
  assign in_bit  = (state_q == HUNT) ? bit_s : (bit_s ^ pol_q);
  assign rx_word = {sh_q[SYNC_WIDTH-2:0], in_bit};
  assign rx_byte = rx_word[BYTE_WIDTH-1:0];

  // Next-state and output decode; the FSM only moves on a sample strobe.
  // NOTE: every variable gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    byte_d    = byte_q;
    pol_d     = pol_q;
    valid_d   = 1'b0;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    chk_err_d = 1'b0;

    if (!en) begin
      state_d   = HUNT;
      sh_d      = '0;
      bit_cnt_d = '0;
      pol_d     = 1'b0;
    end else if (strobe) begin
      sh_d = rx_word;
      case (state_q)
        HUNT: begin
          if (rx_word == SYNC_WORD) begin
            state_d   = LEN;
            sof_d     = 1'b1;
            pol_d     = 1'b0;
            bit_cnt_d = '0;
          end
`ifdef POLARITY_AUTO_EN
          else if (rx_word == ~SYNC_WORD) begin
            state_d   = LEN;
            sof_d     = 1'b1;
            pol_d     = 1'b1;
            bit_cnt_d = '0;
          end
`endif
        end
        LEN: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            len_d   = rx_byte;
            sum_d   = rx_byte;
            cnt_d   = '0;
            state_d = (rx_byte == '0) ? CHK : PAY;
          end
        end
        PAY: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_d  = rx_byte;
            valid_d = 1'b1;
            sum_d   = sum_q + rx_byte;
            cnt_d   = cnt_q + 8'd1;
            if ((cnt_q + 8'd1) == len_q) state_d = CHK;
          end
        end
        CHK: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            eof_d     = 1'b1;
            chk_err_d = (rx_byte != sum_q);
            sh_d      = '0;
            pol_d     = 1'b0;
            state_d   = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Frame state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HUNT;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      chk_err_q <= 1'b0;
      pol_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
      chk_err_q <= chk_err_d;
      pol_q     <= pol_d;
    end
  end

  assign byte_out   = byte_q;
  assign byte_valid = valid_q;
  assign sof        = sof_q;
  assign eof        = eof_q;
  assign chk_err    = chk_err_q;
  assign locked     = (state_q != HUNT);

`ifdef POLARITY_AUTO_EN
  assign polarity_inv = pol_q;
`else
  assign polarity_inv = 1'b0;
`endif

endmodule

// File: tb/tb_bpsk_deframer.sv
// Directed bench for bpsk_deframer with an event scoreboard: expected
// sof / byte / eof events are queued as frames are sent and matched in
// order as the DUT pulses them.
module tb_bpsk_deframer;

  localparam int SPB = 20;
  localparam logic [1:0] K_SOF  = 2'd0;
  localparam logic [1:0] K_BYTE = 2'd1;
  localparam logic [1:0] K_EOF  = 2'd2;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] data;
    logic       flag;  // sof/byte: expected polarity_inv, eof: expected chk_err
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       bit_in;
  logic [7:0] byte_out;
  logic       byte_valid, sof, eof, chk_err, locked, polarity_inv;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  bpsk_deframer #(.SAMPLES_PER_BIT(SPB), .SYNC_WORD(16'hD391)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .bit_in      (bit_in),
    .byte_out    (byte_out),
    .byte_valid  (byte_valid),
    .sof         (sof),
    .eof         (eof),
    .chk_err     (chk_err),
    .locked      (locked),
    .polarity_inv(polarity_inv)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [7:0] d, input logic f);
    exp_t e;
    e.kind = k;
    e.data = d;
    e.flag = f;
    exp_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with an observed event.
  task automatic score(input logic [1:0] k, input logic [7:0] d, input logic f);
    exp_t e;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL unexpected_event observed=%0d/%02h/%0b expected=none", k, d, f);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      assert ({k, d, f} === {e.kind, e.data, e.flag}) else begin
        errors++;
        $error("FAIL event observed=%0d/%02h/%0b expected=%0d/%02h/%0b",
               k, d, f, e.kind, e.data, e.flag);
      end
    end
  endtask

  // Monitor: sample pulses on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (sof)        score(K_SOF, 8'h00, polarity_inv);
    if (byte_valid) score(K_BYTE, byte_out, polarity_inv);
    if (eof)        score(K_EOF, 8'h00, chk_err);
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    bit_in = b;
    repeat (SPB - 1) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit inv);
    for (int i = 7; i >= 0; i--) send_bit(b[i] ^ inv);
  endtask

  task automatic idle(input int n, input logic level);
    for (int i = 0; i < n; i++) send_bit(level);
  endtask

  // Nominal frame 0xD391 03 41 42 43 C9 with its expected events.
  task automatic nominal_frame(input bit inv, input bit expect_lock);
    if (expect_lock) begin
      push(K_SOF, 8'h00, inv);
      push(K_BYTE, 8'h41, inv);
      push(K_BYTE, 8'h42, inv);
      push(K_BYTE, 8'h43, inv);
      push(K_EOF, 8'h00, 1'b0);
    end
    send_byte(8'hD3, inv);
    send_byte(8'h91, inv);
    send_byte(8'h03, inv);
    send_byte(8'h41, inv);
    send_byte(8'h42, inv);
    send_byte(8'h43, inv);
    send_byte(8'hC9, inv);
  endtask

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    bit_in = 1'b0;
    repeat (4) @(negedge clk);

    // Reset state.
    check("rst_byte_out", byte_out, 8'h00);
    check("rst_pulses", {byte_valid, sof, eof, chk_err}, 4'b0000);
    check("rst_locked", locked, 1'b0);
    check("rst_pol", polarity_inv, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;

    // Nominal frame, with a mid-frame lock check.
    idle(8, 1'b0);
    push(K_SOF, 8'h00, 1'b0);
    push(K_BYTE, 8'h41, 1'b0);
    push(K_BYTE, 8'h42, 1'b0);
    push(K_BYTE, 8'h43, 1'b0);
    push(K_EOF, 8'h00, 1'b0);
    send_byte(8'hD3, 1'b0);
    send_byte(8'h91, 1'b0);
    check("nom_locked_mid", locked, 1'b1);
    send_byte(8'h03, 1'b0);
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b0);
    send_byte(8'h43, 1'b0);
    send_byte(8'hC9, 1'b0);
    idle(4, 1'b0);
    check("nom_all_events", exp_q.size(), 0);
    check("nom_locked_after", locked, 1'b0);
    check("nom_byte_hold", byte_out, 8'h43);

    // Bad checksum.
    idle(8, 1'b0);
    push(K_SOF, 8'h00, 1'b0);
    push(K_BYTE, 8'h41, 1'b0);
    push(K_BYTE, 8'h42, 1'b0);
    push(K_BYTE, 8'h43, 1'b0);
    push(K_EOF, 8'h00, 1'b1);
    send_byte(8'hD3, 1'b0);
    send_byte(8'h91, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b0);
    send_byte(8'h43, 1'b0);
    send_byte(8'hC8, 1'b0);
    idle(4, 1'b0);
    check("badchk_all_events", exp_q.size(), 0);

    // Zero-length frame.
    idle(8, 1'b0);
    push(K_SOF, 8'h00, 1'b0);
    push(K_EOF, 8'h00, 1'b0);
    send_byte(8'hD3, 1'b0);
    send_byte(8'h91, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    idle(4, 1'b0);
    check("zero_all_events", exp_q.size(), 0);
    check("zero_locked_after", locked, 1'b0);

    // Sync word carried as payload: 2 + D3 + 91 = 0x166 -> 0x66.
    idle(8, 1'b0);
    push(K_SOF, 8'h00, 1'b0);
    push(K_BYTE, 8'hD3, 1'b0);
    push(K_BYTE, 8'h91, 1'b0);
    push(K_EOF, 8'h00, 1'b0);
    send_byte(8'hD3, 1'b0);
    send_byte(8'h91, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'hD3, 1'b0);
    send_byte(8'h91, 1'b0);
    send_byte(8'h66, 1'b0);
    idle(4, 1'b0);
    check("syncpay_all_events", exp_q.size(), 0);

    // Fully inverted stream including idle.
    idle(8, 1'b1);
`ifdef POLARITY_AUTO_EN
    nominal_frame(1'b1, 1'b1);
`else
    nominal_frame(1'b1, 1'b0);
`endif
    idle(4, 1'b1);
    check("inv_all_events", exp_q.size(), 0);
    check("inv_pol_after", polarity_inv, 1'b0);
    check("inv_locked_after", locked, 1'b0);

    // Abort by dropping en after the second payload byte.
    idle(8, 1'b0);
    push(K_SOF, 8'h00, 1'b0);
    push(K_BYTE, 8'h41, 1'b0);
    push(K_BYTE, 8'h42, 1'b0);
    send_byte(8'hD3, 1'b0);
    send_byte(8'h91, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b0);
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_en_locked", locked, 1'b0);
    check("abort_en_byte_hold", byte_out, 8'h42);
    idle(12, 1'b1);
    check("abort_en_no_eof", exp_q.size(), 0);
    en = 1'b1;
    idle(8, 1'b0);
    nominal_frame(1'b0, 1'b1);
    idle(4, 1'b0);
    check("after_en_abort_events", exp_q.size(), 0);

    // Abort by pulsing rst mid-payload.
    idle(8, 1'b0);
    push(K_SOF, 8'h00, 1'b0);
    push(K_BYTE, 8'h41, 1'b0);
    send_byte(8'hD3, 1'b0);
    send_byte(8'h91, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h41, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_rst_locked", locked, 1'b0);
    check("abort_rst_byte_out", byte_out, 8'h00);
    rst = 1'b0;
    idle(12, 1'b0);
    check("abort_rst_no_eof", exp_q.size(), 0);
    nominal_frame(1'b0, 1'b1);
    idle(4, 1'b0);
    check("after_rst_abort_events", exp_q.size(), 0);
    check("final_locked", locked, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bpsk_deframer.md
Name: bpsk_deframer

Overview:
- Receive-side link layer that sits after bpsk_demodulator_top.
- Recovers bit timing from the demodulated bit stream and hunts for a 16-bit sync word.
- Then extracts a length byte, the payload bytes and a checksum byte.
- It is the counterpart of the TX framer that feeds bpsk_modulator_top; payload bytes go out on a valid-only byte interface.

Parameters:
- SAMPLES_PER_BIT, 20: clk cycles per BPSK symbol; must be ≥4 and even.
- SYNC_WORD, 16'hD391: frame sync pattern, MSB first.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- en  in  1  deframer enable
- bit_in  in  1  demodulated bit (bpsk_demodulator_top data_out), synchronous to clk
- byte_out  out  8  payload byte, MSB first on air
- byte_valid  out  1  one-cycle pulse; byte_out valid
- sof  out  1  one-cycle pulse when sync word matched
- eof  out  1  one-cycle pulse after checksum byte received
- chk_err  out  1  valid with eof; 1 = checksum mismatch
- locked  out  1  high while state ≠ HUNT
- polarity_inv  out  1  current frame received inverted (0 when macro off)

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: all outputs 0, state HUNT, shift register 0, phase 0.
- Reset mid-frame aborts immediately; no eof is produced.

Bit sync:
- bit_q registers bit_in; an edge is bit_in≠bit_q.
- On an edge, phase loads 1; otherwise phase increments and wraps SAMPLES_PER_BIT-1→0.
- Sample strobe fires when phase==SAMPLES_PER_BIT/2; the sampled bit is bit_q.
- Result: first strobe comes SAMPLES_PER_BIT/2 cycles after the transition is visible on bit_in, then every SAMPLES_PER_BIT cycles without edges.

FSM (advances only on strobe):
- HUNT: 16-bit shift register, new bit enters the LSB. On match with SYNC_WORD → LEN, pulse sof the cycle after the strobe.
- LEN: collect 8 bits → len. Checksum sum initialised to len. len==0 → CHK, else → PAY.
- PAY: collect 8-bit bytes.
  - Each completed byte: byte_out=byte, byte_valid pulse the cycle after its last strobe, sum+=byte mod 256, count+=1.
  - count==len → CHK.
- CHK: collect 8 bits. eof pulses the cycle after the last strobe, with chk_err=(rx≠sum). Shift register cleared, → HUNT.
- Sync patterns inside LEN/PAY/CHK are data, never a resync.
- en=0: strobes suppressed; state forced to HUNT, shift register cleared; no eof; outputs held 0 except byte_out, which holds its last value.
- byte_out holds its value between pulses.
- Bit counter is 3 bits, wraps 7→0; byte count is 8 bits, so max payload is 255.

Optional Feature:
- Macro POLARITY_AUTO_EN.
- Defined:
  - HUNT also matches ~SYNC_WORD.
  - An inverted match sets polarity_inv and pulses sof; all subsequent bits of the frame are inverted before use.
  - A true match clears polarity_inv.
  - polarity_inv clears on return to HUNT, en=0 or rst.
  - This resolves the BPSK 180° ambiguity.
- Undefined: only the true pattern matches; polarity_inv tied 0.

Decomposition:
- Package bpsk_frame_pkg holds:
  - typedef enum state_t {HUNT, LEN, PAY, CHK}
  - SYNC_WIDTH=16
  - BYTE_WIDTH=8
  - default SYNC_WORD
  - default SAMPLES_PER_BIT
- One sub-module, bpsk_bit_sync: edge detect, phase counter, strobe and sampled bit. It is reusable by a future clock-recovery upgrade.

Test Plan:
- Nominal frame, SPB=20: stream 0xD391, 0x03, 0x41, 0x42, 0x43, 0xC9 → sof once; byte_valid ×3 with 0x41/0x42/0x43; eof with chk_err=0; locked low after eof.
- Bad checksum: same frame, check byte 0xC8 → three bytes delivered; eof with chk_err=1.
- Zero length: 0xD391, 0x00, 0x00 → sof, no byte_valid, eof with chk_err=0.
- Sync inside payload: len=2, payload 0xD3,0x91, chk 0x66 → both bytes delivered as data, single sof, eof with chk_err=0.
- Inverted stream: every bit of the nominal frame inverted.
  - With POLARITY_AUTO_EN: polarity_inv=1, bytes 0x41/0x42/0x43, chk_err=0.
  - Without it: no sof, no byte_valid.
- Abort: drop en (or pulse rst) after the second payload byte → no eof, state HUNT, locked=0; the next full nominal frame decodes correctly.
